ibex_bus_arb: RTL and testbench
===============================

IBEX_BUS_ARB -- requirements
Module: ibex_bus_arb

Interface
REQ-001 The block SHALL have parameter NumChannels, default 2, meaning the number of requester (OBI host) channels; legal range 2..8.
REQ-002 The block SHALL have parameter MaxOutstanding, default 4, meaning the response-routing FIFO depth; legal range 1..16.
REQ-003 The block SHALL have parameter AddrWidth, default 32, meaning the address width.
REQ-004 The block SHALL have parameter DataWidth, default 32, meaning the data width; byte-enable width is DataWidth/8.
REQ-005 clk_i  in  1  single clock; all state updates on rising edge.
REQ-006 rst_i  in  1  reset, synchronous, active-high.
REQ-007 ch_req_i  in  NumChannels  per-channel request.
REQ-008 ch_gnt_o  out  NumChannels  per-channel grant.
REQ-009 ch_we_i  in  NumChannels  per-channel write enable.
REQ-010 ch_be_i, ch_addr_i, ch_wdata_i  in  NumChannels x (DataWidth/8, AddrWidth, DataWidth)  per-channel byte enables, address and write data.
REQ-011 ch_rvalid_o, ch_err_o  out  NumChannels  per-channel response valid and error.
REQ-012 ch_rdata_o  out  DataWidth  read data, broadcast to all channels.
REQ-013 host_req_o, host_we_o, host_be_o, host_addr_o, host_wdata_o  out  1,1,DataWidth/8,AddrWidth,DataWidth  merged bus request.
REQ-014 host_gnt_i, host_rvalid_i, host_err_i  in  1  bus grant, response valid, response error.
REQ-015 host_rdata_i  in  DataWidth  bus read data.
REQ-016 err_cnt_o  out  16  count of error responses (see Configuration).

Function
REQ-017 The block SHALL assert host_req_o when at least one ch_req_i bit is set and the outstanding count is below MaxOutstanding; host_rvalid_i in the same cycle SHALL NOT free a slot.
REQ-018 Arbitration SHALL be round-robin: search starts at last-granted index + 1, wrapping from NumChannels-1 to 0.
REQ-019 While host_req_o is high and host_gnt_i is low, the selected channel SHALL be locked, so host address, data and controls stay stable until grant (OBI rule).
REQ-020 The block SHALL drive ch_gnt_o[sel] = host_gnt_i & host_req_o combinationally in the same cycle; all other grant bits SHALL be 0.
REQ-021 On each accepted request (host_req_o & host_gnt_i), the block SHALL push sel into the routing FIFO, update last-granted to sel, and release the lock.
REQ-022 On host_rvalid_i with FIFO non-empty, the block SHALL assert ch_rvalid_o[head] and ch_err_o[head] = host_err_i in the same cycle, then pop the FIFO.
REQ-023 The block SHALL drop host_rvalid_i with FIFO empty: no ch_rvalid_o bit set and no state change.
REQ-024 A simultaneous push and pop SHALL leave the count unchanged; FIFO pointers SHALL wrap modulo MaxOutstanding.
REQ-025 The outstanding count width SHALL be $clog2(MaxOutstanding+1); the channel-index width SHALL be max(1,$clog2(NumChannels)).
REQ-026 Responses SHALL be returned strictly in bus order; no reordering.

Reset
REQ-027 While rst_i is high at a clock edge, the block SHALL clear the FIFO, zero the count, release the lock, set last-granted to NumChannels-1 (so channel 0 wins first) and clear err_cnt_o.
REQ-028 During and after reset, all outputs SHALL be 0 until new requests arrive; in-flight transactions are discarded, and later rvalids fall under REQ-023.

Configuration
REQ-029 With macro IBEX_BUS_ARB_ERR_COUNT_EN defined, err_cnt_o SHALL increment on each routed response with host_err_i=1 and saturate at 16'hFFFF.
REQ-030 Without IBEX_BUS_ARB_ERR_COUNT_EN, err_cnt_o SHALL be tied to 0 and the block SHALL contain no counter register.

Verification
REQ-031 NumChannels=2; ch0 and ch1 req held, host_gnt_i=1 every cycle -> grants alternate ch0, ch1, ch0, ch1 from reset.
REQ-032 ch1 req, host_gnt_i=0 for 3 cycles, ch0 raises req in cycle 2 -> host_addr_o stays ch1_addr until grant; ch0 granted next.
REQ-033 MaxOutstanding=4; 4 grants, no rvalid -> host_req_o=0 with requests pending; one rvalid -> host_req_o=1 the following cycle.
REQ-034 Grants ch1, ch0, ch1, then 3 rvalids with rdata A, B, C -> ch1 gets A, ch0 gets B, ch1 gets C.
REQ-035 host_rvalid_i with empty FIFO -> no ch_rvalid_o, count stays 0; rst_i mid-transaction with 2 outstanding -> count 0, ch0 granted first afterwards.
REQ-036 Macro defined, 3 responses with host_err_i=1 -> err_cnt_o=3 and ch_err_o pulses on the owning channel; macro undefined -> err_cnt_o=0.

Source files
------------

// File: rtl/ibex_bus_arb.sv
// Round-robin OBI arbiter merging NumChannels hosts onto one bus; optional error counter under IBEX_BUS_ARB_ERR_COUNT_EN.
// Latency: grant and response routing combinational; backpressure: request held locked until host_gnt_i, stalls at MaxOutstanding.
module ibex_bus_arb #(
  parameter int NumChannels    = 2,
  parameter int MaxOutstanding = 4,
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 32
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic [NumChannels-1:0]                    ch_req_i,
  output logic [NumChannels-1:0]                    ch_gnt_o,
  input  logic [NumChannels-1:0]                    ch_we_i,
  input  logic [NumChannels-1:0][DataWidth/8-1:0]   ch_be_i,
  input  logic [NumChannels-1:0][AddrWidth-1:0]     ch_addr_i,
  input  logic [NumChannels-1:0][DataWidth-1:0]     ch_wdata_i,
  output logic [NumChannels-1:0]                    ch_rvalid_o,
  output logic [NumChannels-1:0]                    ch_err_o,
  output logic [DataWidth-1:0]                      ch_rdata_o,
  output logic                                      host_req_o,
  output logic                                      host_we_o,
  output logic [DataWidth/8-1:0]                    host_be_o,
  output logic [AddrWidth-1:0]                      host_addr_o,
  output logic [DataWidth-1:0]                      host_wdata_o,
  input  logic                                      host_gnt_i,
  input  logic                                      host_rvalid_i,
  input  logic                                      host_err_i,
  input  logic [DataWidth-1:0]                      host_rdata_i,
  output logic [15:0]                               err_cnt_o
);

  localparam int IdxW = (NumChannels > 1) ? $clog2(NumChannels) : 1;
  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  logic [IdxW-1:0] fifo_q [MaxOutstanding];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] cnt_q;
  logic [IdxW-1:0] last_q, lock_idx_q;
  logic            lock_q;

  logic [IdxW-1:0] rr_sel, sel, head;
  logic            room, accept, rsp;
  int              rr_idx;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  // Walk downwards so the last hit is the nearest requester after last_q.
  always_comb begin
    rr_sel = last_q;
    rr_idx = 0;
    for (int i = NumChannels; i >= 1; i--) begin
      rr_idx = (int'(last_q) + i) % NumChannels;
      if (ch_req_i[IdxW'(rr_idx)]) rr_sel = IdxW'(rr_idx);
    end
  end

  assign room       = cnt_q < CntW'(MaxOutstanding);
  assign sel        = lock_q ? lock_idx_q : rr_sel;
  assign host_req_o = ~rst_i & ((|ch_req_i) | lock_q) & room;
  assign accept     = host_req_o & host_gnt_i;
  assign head       = fifo_q[rptr_q];
  assign rsp        = ~rst_i & host_rvalid_i & (cnt_q != '0);

  assign host_we_o    = host_req_o & ch_we_i[sel];
  assign host_be_o    = host_req_o ? ch_be_i[sel]    : '0;
  assign host_addr_o  = host_req_o ? ch_addr_i[sel]  : '0;
  assign host_wdata_o = host_req_o ? ch_wdata_i[sel] : '0;
  assign ch_rdata_o   = host_rdata_i;

  always_comb begin
    ch_gnt_o          = '0;
    ch_rvalid_o       = '0;
    ch_err_o          = '0;
    ch_gnt_o[sel]     = accept;
    ch_rvalid_o[head] = rsp;
    ch_err_o[head]    = rsp & host_err_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      last_q     <= IdxW'(NumChannels - 1);
    end else begin
      if (accept) begin
        wptr_q <= ptr_inc(wptr_q);
        last_q <= sel;
        lock_q <= 1'b0;
      end else if (host_req_o) begin
        lock_q     <= 1'b1;
        lock_idx_q <= sel;
      end
      if (rsp) rptr_q <= ptr_inc(rptr_q);
      cnt_q <= cnt_q + CntW'(accept) - CntW'(rsp);
    end
  end

  // Storage needs no reset: pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (accept) fifo_q[wptr_q] <= sel;
  end

`ifdef IBEX_BUS_ARB_ERR_COUNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
    end else if (rsp && host_err_i && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ibex_bus_arb.sv
// Directed bench for ibex_bus_arb (2 channels, 4 outstanding) with a response-owner scoreboard.
module tb_ibex_bus_arb;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [1:0]       ch_req_i, ch_gnt_o, ch_we_i, ch_rvalid_o, ch_err_o;
  logic [1:0][3:0]  ch_be_i;
  logic [1:0][31:0] ch_addr_i, ch_wdata_i;
  logic [31:0]      ch_rdata_o;
  logic             host_req_o, host_we_o;
  logic [3:0]       host_be_o;
  logic [31:0]      host_addr_o, host_wdata_o;
  logic             host_gnt_i, host_rvalid_i, host_err_i;
  logic [31:0]      host_rdata_i;
  logic [15:0]      err_cnt_o;

  int   errors = 0;
  int   checks = 0;
  logic sb [$];

  ibex_bus_arb dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ch_req_i     (ch_req_i),
    .ch_gnt_o     (ch_gnt_o),
    .ch_we_i      (ch_we_i),
    .ch_be_i      (ch_be_i),
    .ch_addr_i    (ch_addr_i),
    .ch_wdata_i   (ch_wdata_i),
    .ch_rvalid_o  (ch_rvalid_o),
    .ch_err_o     (ch_err_o),
    .ch_rdata_o   (ch_rdata_o),
    .host_req_o   (host_req_o),
    .host_we_o    (host_we_o),
    .host_be_o    (host_be_o),
    .host_addr_o  (host_addr_o),
    .host_wdata_o (host_wdata_o),
    .host_gnt_i   (host_gnt_i),
    .host_rvalid_i(host_rvalid_i),
    .host_err_i   (host_err_i),
    .host_rdata_i (host_rdata_i),
    .err_cnt_o    (err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expects channel ch to be granted this cycle and records it as owner of the next response.
  task automatic expect_grant(input logic ch);
    chk("grant_req", {63'd0, host_req_o}, 64'd1);
    chk("grant_onehot", {62'd0, ch_gnt_o}, ch ? 64'd2 : 64'd1);
    chk("grant_addr", {32'd0, host_addr_o}, {32'd0, ch_addr_i[ch]});
    chk("grant_wdata", {32'd0, host_wdata_o}, {32'd0, ch_wdata_i[ch]});
    chk("grant_be", {60'd0, host_be_o}, {60'd0, ch_be_i[ch]});
    chk("grant_we", {63'd0, host_we_o}, {63'd0, ch_we_i[ch]});
    sb.push_back(ch);
  endtask

  // Drives one bus response; leaves host_rvalid_i high for the caller to clear.
  task automatic respond(input logic [31:0] rdata, input logic err);
    logic       owner;
    logic [1:0] exp_v;
    host_rvalid_i = 1'b1;
    host_rdata_i  = rdata;
    host_err_i    = err;
    #2;
    exp_v = 2'b00;
    if (sb.size() > 0) begin
      owner = sb.pop_front();
      exp_v = owner ? 2'b10 : 2'b01;
    end
    chk("rsp_rvalid", {62'd0, ch_rvalid_o}, {62'd0, exp_v});
    chk("rsp_err", {62'd0, ch_err_o}, {62'd0, err ? exp_v : 2'b00});
    if (exp_v != 2'b00) chk("rsp_rdata", {32'd0, ch_rdata_o}, {32'd0, rdata});
  endtask

  initial begin
    rst_i         = 1'b1;
    ch_req_i      = 2'b00;
    ch_we_i       = 2'b10;
    ch_be_i[0]    = 4'hF;
    ch_be_i[1]    = 4'h3;
    ch_addr_i[0]  = 32'h1000_0000;
    ch_addr_i[1]  = 32'h2000_0004;
    ch_wdata_i[0] = 32'hAAAA_0000;
    ch_wdata_i[1] = 32'hBBBB_1111;
    host_gnt_i    = 1'b0;
    host_rvalid_i = 1'b0;
    host_err_i    = 1'b0;
    host_rdata_i  = 32'h0;
    cyc();
    cyc();
    rst_i = 1'b0;
    #2;
    chk("reset_req", {63'd0, host_req_o}, 64'd0);
    chk("reset_gnt", {62'd0, ch_gnt_o}, 64'd0);
    chk("reset_rvalid", {62'd0, ch_rvalid_o}, 64'd0);
    chk("reset_errcnt", {48'd0, err_cnt_o}, 64'd0);
    cyc();

    // Both requesting with a free-running grant: strict alternation from channel 0.
    ch_req_i   = 2'b11;
    host_gnt_i = 1'b1;
    #2; expect_grant(1'b0); cyc();
    #2; expect_grant(1'b1); cyc();
    #2; expect_grant(1'b0); cyc();
    #2; expect_grant(1'b1); cyc();
    #2;
    chk("full_req", {63'd0, host_req_o}, 64'd0);
    chk("full_gnt", {62'd0, ch_gnt_o}, 64'd0);
    respond(32'h0000_A0A0, 1'b0);
    chk("full_rvalid_same_cycle", {63'd0, host_req_o}, 64'd0);
    cyc();
    host_rvalid_i = 1'b0;
    #2; expect_grant(1'b0); cyc();

    // Drain in bus order: owners 1,0,1,0.
    ch_req_i   = 2'b00;
    host_gnt_i = 1'b0;
    respond(32'h0000_000A, 1'b0); cyc();
    respond(32'h0000_000B, 1'b0); cyc();
    respond(32'h0000_000C, 1'b0); cyc();
    respond(32'h0000_000D, 1'b0); cyc();
    respond(32'hDEAD_BEEF, 1'b0); cyc();
    host_rvalid_i = 1'b0;

    // Make channel 1 the last winner, then hold channel 1 ungranted while channel 0 joins.
    ch_req_i   = 2'b10;
    host_gnt_i = 1'b1;
    #2; expect_grant(1'b1); cyc();
    host_gnt_i = 1'b0;
    #2;
    chk("lock_c1_addr", {32'd0, host_addr_o}, {32'd0, ch_addr_i[1]});
    chk("lock_c1_gnt", {62'd0, ch_gnt_o}, 64'd0);
    cyc();
    ch_req_i = 2'b11;
    #2;
    chk("lock_c2_addr", {32'd0, host_addr_o}, {32'd0, ch_addr_i[1]});
    chk("lock_c2_req", {63'd0, host_req_o}, 64'd1);
    cyc();
    #2;
    chk("lock_c3_addr", {32'd0, host_addr_o}, {32'd0, ch_addr_i[1]});
    cyc();
    host_gnt_i = 1'b1;
    #2; expect_grant(1'b1); cyc();
    #2; expect_grant(1'b0); cyc();
    #2; expect_grant(1'b1); cyc();
    #2;
    chk("full2_req", {63'd0, host_req_o}, 64'd0);
    ch_req_i   = 2'b00;
    host_gnt_i = 1'b0;

    // Owners 1,1,0,1 with three error responses.
    respond(32'h1111_0001, 1'b1); cyc();
    respond(32'h1111_0002, 1'b1); cyc();
    respond(32'h1111_0003, 1'b0); cyc();
    respond(32'h1111_0004, 1'b1); cyc();
    host_rvalid_i = 1'b0;
    host_err_i    = 1'b0;
    #2;
`ifdef IBEX_BUS_ARB_ERR_COUNT_EN
    chk("err_cnt", {48'd0, err_cnt_o}, 64'd3);
`else
    chk("err_cnt", {48'd0, err_cnt_o}, 64'd0);
`endif
    cyc();

    // Reset with two transactions in flight discards them.
    ch_req_i   = 2'b11;
    host_gnt_i = 1'b1;
    #2; expect_grant(1'b0); cyc();
    #2; expect_grant(1'b1); cyc();
    rst_i = 1'b1;
    #2;
    chk("midrst_req", {63'd0, host_req_o}, 64'd0);
    chk("midrst_gnt", {62'd0, ch_gnt_o}, 64'd0);
    cyc();
    rst_i = 1'b0;
    sb.delete();
    #2;
    expect_grant(1'b0);
    chk("midrst_errcnt", {48'd0, err_cnt_o}, 64'd0);
    cyc();
    ch_req_i   = 2'b00;
    host_gnt_i = 1'b0;
    respond(32'h5555_0001, 1'b0); cyc();
    respond(32'h5555_0002, 1'b0); cyc();
    host_rvalid_i = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
